// File: rtl/param_sequencer_pkg.sv
// Shared constants and next-pc select encoding for the instruction sequencer.
package seq_pkg;
  localparam int DEF_PC_W      = 5;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_PHASES    = 4;
  localparam int DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_JR,
    SEL_RET
  } sel_e;
endpackage

// File: rtl/param_sequencer_if.sv
// Control inputs and status outputs of the sequencer; slave is the sequencer side.
interface param_sequencer_if
  import seq_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PHASES = DEF_PHASES
);
  localparam int PH_W = $clog2(PHASES);

  logic              stall;
  logic              br_taken;
  logic [DATA_W-1:0] pc_add;
  logic              jump;
  logic [DATA_W-1:0] inst_addr;
  logic              call;
  logic              ret;
  logic              jr;
  logic [DATA_W-1:0] rs_d;
  logic [PC_W-1:0]   pc;
  logic [PH_W-1:0]   phase;
  logic              commit;
  logic              ras_empty;
  logic              ras_full;
  logic [1:0]        ras_err;

  modport master (
    output stall, br_taken, pc_add, jump, inst_addr, call, ret, jr, rs_d,
    input  pc, phase, commit, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, br_taken, pc_add, jump, inst_addr, call, ret, jr, rs_d,
    output pc, phase, commit, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/param_sequencer_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Pop on empty leaves state untouched and only raises o_underflow.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_overflow,
  output logic         o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_sp;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] w_top;

  assign w_top       = r_sp - 1'b1;
  assign o_dat       = r_mem[w_top];
  assign o_empty     = (r_cnt == '0);
  assign o_full      = (r_cnt == CNT_FULL);
  assign o_overflow  = i_push && o_full;
  assign o_underflow = i_pop && !i_push && o_empty;

  // r_sp is the next write slot; when full that slot holds the oldest entry
  always_ff @(posedge clock) begin
    if (!reset && i_push) begin
      r_mem[r_sp] <= i_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_sp <= r_sp + 1'b1;
      if (!o_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (i_pop && !o_empty) begin
      r_sp  <= w_top;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/param_sequencer.sv
// Multi-phase program sequencer: pc advances once per PHASES clocks with
// branch/jump/jr/call/ret handling and a return-address stack.
module param_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PHASES    = DEF_PHASES,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  param_sequencer_if.slave  bus
);
  localparam int PH_W = $clog2(PHASES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  logic [PC_W-1:0] r_pc;
  logic [PH_W-1:0] r_phase;
  logic [1:0]      r_err;

  logic            w_commit;
  sel_e            w_sel;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_ras_dat;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_ras_ovf;
  logic            w_ras_unf;
  logic            w_unused_bits;

  assign w_commit = (r_phase == PH_LAST) && !bus.stall;
  assign w_pc_inc = r_pc + 1'b1;
  assign w_push   = w_commit && bus.call && bus.jump && !bus.ret && !bus.jr;
  assign w_pop    = w_commit && bus.ret;

  assign w_unused_bits = ^{bus.pc_add[DATA_W-1:PC_W+2], bus.pc_add[1:0],
                           bus.inst_addr[DATA_W-1:PC_W+2], bus.inst_addr[1:0],
                           bus.rs_d[DATA_W-1:PC_W]};

  // A ret against an empty stack falls back to the increment path
  always_comb begin
    w_sel = SEL_INC;
    if (bus.ret) begin
      w_sel = w_ras_empty ? SEL_INC : SEL_RET;
    end else if (bus.jr) begin
      w_sel = SEL_JR;
    end else if (bus.jump) begin
      w_sel = SEL_JMP;
    end else if (bus.br_taken) begin
      w_sel = SEL_BR;
    end
  end

  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_sel)
      SEL_BR:  w_pc_nxt = r_pc + bus.pc_add[PC_W+1:2];
      SEL_JMP: w_pc_nxt = bus.inst_addr[PC_W+1:2];
      SEL_JR:  w_pc_nxt = bus.rs_d[PC_W-1:0];
      SEL_RET: w_pc_nxt = w_ras_dat;
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_dat       (w_pc_inc),
    .o_dat       (w_ras_dat),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full),
    .o_overflow  (w_ras_ovf),
    .o_underflow (w_ras_unf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= '0;
      r_phase <= '0;
      r_err   <= '0;
    end else begin
      if (!bus.stall) begin
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      end
      if (w_commit) begin
        r_pc  <= w_pc_nxt;
        r_err <= r_err | {w_ras_ovf, w_ras_unf};
      end
    end
  end

  assign bus.pc        = r_pc;
  assign bus.phase     = r_phase;
  assign bus.commit    = w_commit;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_err   = r_err;
endmodule

// File: tb/tb_param_sequencer.sv
// Randomized and directed bench for param_sequencer against a queue-based reference model.
module tb_param_sequencer;
  localparam int PHASES = 4;
  localparam int DEPTH  = 4;
  localparam int PCMOD  = 32;

  logic clock;
  logic reset;

  param_sequencer_if bus ();

  param_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_pc;
  int          m_ph;
  int unsigned m_err;
  int          m_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_ctl();
    bus.stall = 0; bus.br_taken = 0; bus.jump = 0; bus.call = 0;
    bus.ret = 0; bus.jr = 0; bus.pc_add = '0; bus.inst_addr = '0; bus.rs_d = '0;
  endtask

  // Advance the model from the inputs present at this edge, then let outputs settle.
  task automatic tick();
    bit cm;
    @(posedge clock);
    if (reset) begin
      m_pc = 0; m_ph = 0; m_err = 0; m_q.delete();
    end else begin
      cm = (m_ph == PHASES - 1) && !bus.stall;
      if (!bus.stall) m_ph = (m_ph + 1) % PHASES;
      if (cm) begin
        if (bus.ret) begin
          if (m_q.size() > 0) m_pc = m_q.pop_back();
          else begin m_pc = (m_pc + 1) % PCMOD; m_err |= 1; end
        end else if (bus.jr) begin
          m_pc = int'(bus.rs_d % 32);
        end else if (bus.jump) begin
          if (bus.call) begin
            m_q.push_back((m_pc + 1) % PCMOD);
            if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_err |= 2; end
          end
          m_pc = int'(bus.inst_addr >> 2) % PCMOD;
        end else if (bus.br_taken) begin
          m_pc = (m_pc + int'(bus.pc_add >> 2)) % PCMOD;
        end else begin
          m_pc = (m_pc + 1) % PCMOD;
        end
      end
    end
    #1;
  endtask

  task automatic run_to_commit();
    for (int i = 0; i < PHASES && m_ph != PHASES - 1; i++) tick();
  endtask

  task automatic instr(input logic r, input logic j_r, input logic jmp, input logic cl,
                       input logic br, input logic [31:0] add, input logic [31:0] ia,
                       input logic [31:0] rs);
    run_to_commit();
    bus.ret = r; bus.jr = j_r; bus.jump = jmp; bus.call = cl; bus.br_taken = br;
    bus.pc_add = add; bus.inst_addr = ia; bus.rs_d = rs;
    tick();
    clear_ctl();
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    clear_ctl();
    reset = 1;
    bus.stall = 1; bus.jump = 1; bus.inst_addr = 32'h7C;
    tick(); tick();
    bus.stall = 0;
    tick();
    n_checks++; if (bus.pc !== 5'd0) $display("FAIL reset_pc: got %0d need 0", bus.pc); else n_pass++;
    n_checks++; if (bus.phase !== 2'd0) $display("FAIL reset_phase: got %0d need 0", bus.phase); else n_pass++;
    n_checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0)
      $display("FAIL reset_ras: got empty=%b full=%b need 1/0", bus.ras_empty, bus.ras_full); else n_pass++;
    n_checks++; if (bus.ras_err !== 2'b00) $display("FAIL reset_err: got %b need 00", bus.ras_err); else n_pass++;
    reset = 0;
    clear_ctl();
  endtask

  task automatic test_increment();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      n_checks++; if (bus.commit !== (k % 4 == 0))
        $display("FAIL inc_commit: cycle %0d got %b need %b", k, bus.commit, (k % 4 == 0)); else n_pass++;
      tick();
      n_checks++; if (bus.pc !== 5'(k / 4))
        $display("FAIL inc_pc: cycle %0d got %0d need %0d", k, bus.pc, k / 4); else n_pass++;
    end
    instr(0, 1, 0, 0, 0, 0, 0, 32'd31);
    n_checks++; if (bus.pc !== 5'd31) $display("FAIL inc_jr31: got %0d need 31", bus.pc); else n_pass++;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.pc !== 5'd0) $display("FAIL inc_wrap: got %0d need 0", bus.pc); else n_pass++;
  endtask

  task automatic test_branch();
    instr(0, 1, 0, 0, 0, 0, 0, 32'd3);
    instr(0, 0, 0, 0, 1, 32'h0000000C, 0, 0);
    n_checks++; if (bus.pc !== 5'd6) $display("FAIL br_fwd: got %0d need 6", bus.pc); else n_pass++;
    instr(0, 0, 0, 0, 1, 32'hFFFFFFF8, 0, 0);
    n_checks++; if (bus.pc !== 5'd4) $display("FAIL br_back: got %0d need 4", bus.pc); else n_pass++;
  endtask

  task automatic test_jump();
    instr(0, 0, 1, 0, 0, 0, 32'h40, 0);
    n_checks++; if (bus.pc !== 5'd16) $display("FAIL jmp: got %0d need 16", bus.pc); else n_pass++;
    instr(0, 1, 1, 0, 0, 0, 32'h40, 32'h2A);
    n_checks++; if (bus.pc !== 5'd10) $display("FAIL jr_wins: got %0d need 10", bus.pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    do_reset();
    instr(0, 1, 0, 0, 0, 0, 0, 32'd5);
    instr(0, 0, 1, 1, 0, 0, 32'h20, 0);
    n_checks++; if (bus.pc !== 5'd8 || bus.ras_empty !== 1'b0)
      $display("FAIL call: got pc=%0d empty=%b need 8/0", bus.pc, bus.ras_empty); else n_pass++;
    instr(0, 0, 0, 0, 1, 32'h4, 0, 0);
    instr(1, 0, 0, 1, 0, 0, 32'h7C, 0);
    n_checks++; if (bus.pc !== 5'd6 || bus.ras_empty !== 1'b1 || bus.ras_err !== 2'b00)
      $display("FAIL ret: got pc=%0d empty=%b err=%b need 6/1/00", bus.pc, bus.ras_empty, bus.ras_err); else n_pass++;
  endtask

  task automatic test_stall();
    int pc0;
    for (int i = 0; i < PHASES && m_ph != 2; i++) tick();
    pc0 = m_pc;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.jump = 1; bus.inst_addr = 32'h3C;
      #1;
      n_checks++; if (bus.commit !== 1'b0) $display("FAIL stall_commit: got %b need 0", bus.commit); else n_pass++;
      tick();
      n_checks++; if (bus.phase !== 2'd2 || bus.pc !== 5'(pc0))
        $display("FAIL stall_hold: got phase=%0d pc=%0d need 2/%0d", bus.phase, bus.pc, pc0); else n_pass++;
    end
    clear_ctl();
    tick();
    n_checks++; if (bus.commit !== 1'b1 || bus.pc !== 5'(pc0))
      $display("FAIL stall_release: got commit=%b pc=%0d need 1/%0d", bus.commit, bus.pc, pc0); else n_pass++;
    tick();
    n_checks++; if (bus.pc !== 5'((pc0 + 1) % 32) || bus.phase !== 2'd0)
      $display("FAIL stall_commit_pc: got pc=%0d phase=%0d need %0d/0", bus.pc, bus.phase, (pc0 + 1) % 32); else n_pass++;
  endtask

  task automatic test_ras_overflow();
    int exp_ret[4] = '{14, 13, 12, 11};
    do_reset();
    for (int i = 0; i < 5; i++) instr(0, 0, 1, 1, 0, 0, 32'((10 + i) * 4), 0);
    n_checks++; if (bus.ras_err !== 2'b10 || bus.ras_full !== 1'b1)
      $display("FAIL ovf: got err=%b full=%b need 10/1", bus.ras_err, bus.ras_full); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      instr(1, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.pc !== 5'(exp_ret[i]) || bus.pc !== 5'(m_pc))
        $display("FAIL ret_order: pop %0d got %0d need %0d", i, bus.pc, exp_ret[i]); else n_pass++;
    end
    instr(1, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.pc !== 5'd12 || bus.ras_err !== 2'b11 || bus.ras_empty !== 1'b1)
      $display("FAIL unf: got pc=%0d err=%b empty=%b need 12/11/1", bus.pc, bus.ras_err, bus.ras_empty); else n_pass++;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.ras_err !== 2'b11) $display("FAIL err_sticky: got %b need 11", bus.ras_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    instr(0, 0, 1, 1, 0, 0, 32'h48, 0);
    run_to_commit();
    bus.jump = 1; bus.inst_addr = 32'h7C; bus.call = 1;
    reset = 1;
    tick();
    reset = 0;
    clear_ctl();
    n_checks++; if (bus.pc !== 5'd0 || bus.phase !== 2'd0 || bus.ras_empty !== 1'b1 || bus.ras_err !== 2'b00)
      $display("FAIL reset_mid: got pc=%0d ph=%0d empty=%b err=%b need 0/0/1/00",
               bus.pc, bus.phase, bus.ras_empty, bus.ras_err); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.ret       = ($urandom_range(0, 5) == 0);
      bus.jr        = ($urandom_range(0, 7) == 0);
      bus.jump      = ($urandom_range(0, 3) == 0);
      bus.call      = ($urandom_range(0, 1) == 0);
      bus.br_taken  = ($urandom_range(0, 3) == 0);
      bus.pc_add    = $urandom;
      bus.inst_addr = $urandom;
      bus.rs_d      = $urandom;
      #1;
      n_checks++; if (bus.commit !== ((m_ph == PHASES - 1) && !bus.stall))
        $display("FAIL rnd_commit: cycle %0d got %b need %b", c, bus.commit, (m_ph == PHASES - 1) && !bus.stall);
      else n_pass++;
      tick();
      n_checks++; if (bus.pc !== 5'(m_pc)) $display("FAIL rnd_pc: cycle %0d got %0d need %0d", c, bus.pc, m_pc); else n_pass++;
      n_checks++; if (bus.phase !== 2'(m_ph)) $display("FAIL rnd_phase: cycle %0d got %0d need %0d", c, bus.phase, m_ph); else n_pass++;
      n_checks++; if (bus.ras_empty !== (m_q.size() == 0) || bus.ras_full !== (m_q.size() == DEPTH))
        $display("FAIL rnd_ras: cycle %0d got empty=%b full=%b need depth %0d", c, bus.ras_empty, bus.ras_full, m_q.size());
      else n_pass++;
      n_checks++; if (bus.ras_err !== 2'(m_err)) $display("FAIL rnd_err: cycle %0d got %b need %b", c, bus.ras_err, 2'(m_err)); else n_pass++;
    end
    reset = 0;
    clear_ctl();
  endtask

  initial begin
    reset = 1;
    clear_ctl();
    m_pc = 0; m_ph = 0; m_err = 0;
    test_reset();
    test_increment();
    test_branch();
    test_jump();
    test_call_ret();
    test_stall();
    test_ras_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
